// File: rtl/n_bit_serial_subtractor_if.sv
// Handshake and operand/result bundle for n_bit_serial_subtractor.
// ovf exists only when OVERFLOW_FLAG_EN is defined.
interface n_bit_serial_subtractor_if #(
  parameter int N = 16
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
`ifdef OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  modport master (
    output start, a, b, bin,
`ifdef OVERFLOW_FLAG_EN
    input  ovf,
`endif
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
`ifdef OVERFLOW_FLAG_EN
    output ovf,
`endif
    output busy, done, diff, bout
  );
endinterface

// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial N-bit subtractor, diff = a - b - bin, LSB first, start/busy/done handshake.
// Optional macro OVERFLOW_FLAG_EN adds a signed-overflow flag (ovf) on the interface.
module n_bit_serial_subtractor #(
  parameter int N = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  n_bit_serial_subtractor_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_a_sh;
  logic [N-1:0]    r_b_sh;
  logic [N-1:0]    r_diff;
  logic [CW-1:0]   r_cnt;
  logic            r_borrow;
  logic            r_bout;
  logic            w_accept;
  logic            w_last;
  logic            w_d;
  logic            w_borrow_nxt;
`ifdef OVERFLOW_FLAG_EN
  logic            r_ovf;
`endif

  always_comb begin
    w_accept     = 1'b0;
    w_last       = 1'b0;
    w_d          = 1'b0;
    w_borrow_nxt = 1'b0;
    w_accept     = bus.start && (r_state != S_RUN);
    w_last       = (r_cnt == CW'(N - 1));
    w_d          = r_a_sh[0] ^ r_b_sh[0] ^ r_borrow;
    w_borrow_nxt = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_borrow);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      r_ovf    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a_sh   <= bus.a;
      r_b_sh   <= bus.b;
      r_borrow <= bus.bin;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_diff   <= {w_d, r_diff[N-1:1]};
      r_a_sh   <= {1'b0, r_a_sh[N-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[N-1:1]};
      r_borrow <= w_borrow_nxt;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_bout <= w_borrow_nxt;
`ifdef OVERFLOW_FLAG_EN
        // On the MSB step r_borrow is the borrow into bit N-1.
        r_ovf  <= r_borrow ^ w_borrow_nxt;
`endif
      end
    end
  end

  always_comb begin
    bus.busy = (r_state == S_RUN);
    bus.done = (r_state == S_DONE);
    bus.diff = r_diff;
    bus.bout = r_bout;
`ifdef OVERFLOW_FLAG_EN
    bus.ovf  = r_ovf;
`endif
  end

endmodule

// File: tb/tb_n_bit_serial_subtractor.sv
// Self-checking bench for n_bit_serial_subtractor (N=16): directed cases plus
// randomized operands against an arithmetic reference model.
module tb_n_bit_serial_subtractor;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  n_bit_serial_subtractor_if #(.N(N)) bus ();
  n_bit_serial_subtractor #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N:0] ref_sub(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic bin);
    return {1'b0, a} - {1'b0, b} - (N+1)'(bin);
  endfunction

  function automatic logic ref_ovf(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic bin);
    longint sa, sb, res, lo, hi;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = sa - sb - longint'(bin);
    hi  = (longint'(1) <<< (N - 1)) - 1;
    lo  = -(longint'(1) <<< (N - 1));
    return (res > hi) || (res < lo);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!bus.done && edges < 4 * N) begin
      tick();
      edges++;
    end
  endtask

  task automatic check_result(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic bin);
    logic [N:0] r;
    r = ref_sub(a, b, bin);
    check({tag, "_diff"}, 64'(bus.diff), 64'(r[N-1:0]));
    check({tag, "_bout"}, 64'(bus.bout), 64'(r[N]));
`ifdef OVERFLOW_FLAG_EN
    check({tag, "_ovf"}, 64'(bus.ovf), 64'(ref_ovf(a, b, bin)));
`endif
  endtask

  // Call when the DUT is idle or showing done; leaves the bench in the done cycle.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic bin);
    int e;
    bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_busy"}, 64'(bus.busy), 64'(1));
    bus.a = N'($urandom); bus.b = N'($urandom); bus.bin = 1'($urandom);
    wait_done(e);
    check({tag, "_lat"}, 64'(e), 64'(N));
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
    check_result(tag, a, b, bin);
  endtask

  initial begin
    int e;
    logic seen;
    logic [N-1:0] ra, rb;
    logic rbin;

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    repeat (3) tick();
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_diff", 64'(bus.diff), 64'(0));
    check("rst_bout", 64'(bus.bout), 64'(0));
`ifdef OVERFLOW_FLAG_EN
    check("rst_ovf", 64'(bus.ovf), 64'(0));
`endif
    rst_n = 1'b1;
    tick();
    check("idle_done", 64'(bus.done), 64'(0));

    run_op("basic", 16'h0002, 16'h0000, 1'b0);
    tick();
    check("done_pulse", 64'(bus.done), 64'(0));
    run_op("wrap0", 16'h0000, 16'h0002, 1'b0);
    run_op("wrapF", 16'hFFFF, 16'hFFFF, 1'b1);
    run_op("ovf1", 16'h8000, 16'h0001, 1'b0);
    run_op("ovf0", 16'h0005, 16'h0003, 1'b0);
    run_op("pos_ovf", 16'h7FFF, 16'hFFFF, 1'b0);
    tick();

    // start during RUN is ignored
    bus.a = 16'h00A5; bus.b = 16'h0021; bus.bin = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    bus.a = 16'h1234; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(e);
    check("midstart_lat", 64'(e + 6), 64'(N));
    check_result("midstart", 16'h00A5, 16'h0021, 1'b1);
    tick();

    // start held high through DONE: back-to-back, no bubble
    bus.a = 16'h0100; bus.b = 16'h0001; bus.bin = 1'b0; bus.start = 1'b1;
    tick();
    check("b2b_busy1", 64'(bus.busy), 64'(1));
    bus.a = 16'h0010; bus.b = 16'h0001;
    wait_done(e);
    check("b2b_lat1", 64'(e), 64'(N));
    check_result("b2b1", 16'h0100, 16'h0001, 1'b0);
    tick();
    bus.start = 1'b0;
    check("b2b_busy2", 64'(bus.busy), 64'(1));
    wait_done(e);
    check("b2b_lat2", 64'(e), 64'(N));
    check_result("b2b2", 16'h0010, 16'h0001, 1'b0);
    tick();

    // reset in the middle of an operation
    bus.a = 16'hBEEF; bus.b = 16'h1234; bus.bin = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_busy", 64'(bus.busy), 64'(0));
    check("mrst_done", 64'(bus.done), 64'(0));
    check("mrst_diff", 64'(bus.diff), 64'(0));
    check("mrst_bout", 64'(bus.bout), 64'(0));
    seen = 1'b0;
    repeat (2 * N) begin
      tick();
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("mrst_quiet", 64'(seen), 64'(0));
    run_op("after_rst", 16'h4321, 16'h1234, 1'b0);

    // results hold without a new start
    ra = 16'h1000; rb = 16'h2000; rbin = 1'b1;
    tick();
    run_op("hold_src", ra, rb, rbin);
    for (int unsigned i = 0; i < 20; i++) begin
      bus.a = N'($urandom); bus.b = N'($urandom); bus.bin = 1'($urandom);
      tick();
      check_result("hold", ra, rb, rbin);
    end

    // randomized operands, mixing idle gaps and back-to-back issue
    for (int unsigned i = 0; i < 40; i++) begin
      ra = N'($urandom); rb = N'($urandom); rbin = 1'($urandom);
      if (i % 5 == 0) ra = rb;
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) tick();
      run_op("rand", ra, rb, rbin);
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
